// File: rtl/cdc_pkg.sv
// cdc_pkg: shared types and default constants for the req/ack crossing
// toward the multiplier clock domain.
package cdc_pkg;

  // Four-phase initiator states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_t;

  // Default synchronizer depth on the returning acknowledge.
  localparam int CDC_SYNC_STAGES    = 3;
  // Default per-phase wait limit, only meaningful with HS_TIMEOUT_EN.
  localparam int CDC_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/ack_sync.sv
// ack_sync: SYNC_STAGES-deep flop chain bringing the remote acknowledge into
// the local clock domain. SYNC_STAGES must be at least 2.
module ack_sync
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = CDC_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic ack_in,
  output logic ack_s
);

  logic [SYNC_STAGES-1:0] sync_reg;

  // First stage samples the asynchronous acknowledge.
  always_ff @(posedge clk) begin
    if (rst) sync_reg[0] <= 1'b0;
    else     sync_reg[0] <= ack_in;
  end

  genvar gi;
  generate
    for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_stage
      // Each further stage re-times the previous one to settle metastability.
      always_ff @(posedge clk) begin
        if (rst) sync_reg[gi] <= 1'b0;
        else     sync_reg[gi] <= sync_reg[gi-1];
      end
    end
  endgenerate

  assign ack_s = sync_reg[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source-side four-phase req/ack initiator. Accepts one word
// on a valid/ready port, holds it on data_out and runs req high / ack high /
// req low / ack low before accepting the next word.
// Optional feature macro: HS_TIMEOUT_EN (per-phase wait limit and sticky err).
module cdc_handshake_tx
  import cdc_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int SYNC_STAGES    = CDC_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = CDC_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_in,
  output logic             busy,
`ifdef HS_TIMEOUT_EN
  output logic             err,
`endif
  output logic             done
);

  hs_state_t        state_reg;
  logic             req_reg;
  logic [WIDTH-1:0] data_reg;
  logic             done_reg;
  logic             ack_s;

`ifdef HS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             err_reg;
  // Set when the current transaction was cut short in REQ, so its release
  // phase does not report a normal completion.
  logic             abort_reg;
`endif

  ack_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk    (clk),
    .rst    (rst),
    .ack_in (ack_in),
    .ack_s  (ack_s)
  );

  // Handshake FSM with registered req, data and done; the FSM only ever looks
  // at the synchronized acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      data_reg  <= '0;
      done_reg  <= 1'b0;
`ifdef HS_TIMEOUT_EN
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
      abort_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
`ifdef HS_TIMEOUT_EN
      // Count while waiting in a phase; each transition below restarts it.
      cnt_reg  <= (state_reg == IDLE) ? '0 : cnt_reg + 1'b1;
`endif
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            state_reg <= REQ;
            req_reg   <= 1'b1;
            data_reg  <= in_data;
`ifdef HS_TIMEOUT_EN
            cnt_reg   <= '0;
            abort_reg <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (ack_s) begin
            state_reg <= REL;
            req_reg   <= 1'b0;
`ifdef HS_TIMEOUT_EN
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= REL;
            req_reg   <= 1'b0;
            cnt_reg   <= '0;
            err_reg   <= 1'b1;
            abort_reg <= 1'b1;
`endif
          end
        end
        REL: begin
          if (!ack_s) begin
            state_reg <= IDLE;
`ifdef HS_TIMEOUT_EN
            done_reg  <= !abort_reg;
            cnt_reg   <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b1;
`else
            done_reg  <= 1'b1;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready = (state_reg == IDLE);
  assign busy     = (state_reg != IDLE);
  assign req_out  = req_reg;
  assign data_out = data_reg;
  assign done     = done_reg;
`ifdef HS_TIMEOUT_EN
  assign err      = err_reg;
`endif

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: directed bench for cdc_handshake_tx with a scoreboard
// of accepted words checked against data_out on each done pulse.
// Optional feature macro: HS_TIMEOUT_EN (adds the timeout scenario).
module tb_cdc_handshake_tx;

  localparam int WIDTH = 8;
  localparam int SYNC  = 3;
`ifdef HS_TIMEOUT_EN
  localparam int TMO   = 16;
`else
  localparam int TMO   = 255;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             req_out;
  logic [WIDTH-1:0] data_out;
  logic             ack_in;
  logic             busy;
  logic             done;
`ifdef HS_TIMEOUT_EN
  logic             err;
`endif

  int               n_cmp = 0;
  int               n_bad = 0;
  int               cyc   = 0;
  int               last_done_cyc;
  int               lat;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  cdc_handshake_tx #(
    .WIDTH          (WIDTH),
    .SYNC_STAGES    (SYNC),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .req_out  (req_out),
    .data_out (data_out),
    .ack_in   (ack_in),
    .busy     (busy),
`ifdef HS_TIMEOUT_EN
    .err      (err),
`endif
    .done     (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one word into IDLE and record it in the scoreboard.
  task automatic accept_word(input logic [WIDTH-1:0] w, input bit track);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (track) exp_q.push_back(w);
    check("accept_req", {31'd0, req_out}, 32'd1);
    check("accept_data", {24'd0, data_out}, {24'd0, w});
  endtask

  // Immediate-ack remote model until done; pop and compare on done.
  task automatic complete(output int cycles);
    logic [WIDTH-1:0] w;
    bit               seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      ack_in = req_out;
      tick();
      cycles++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) begin
      if (exp_q.size() == 0) begin
        check("sb_nonempty", 32'd0, 32'd1);
      end else begin
        w = exp_q.pop_front();
        check("sb_word", {24'd0, data_out}, {24'd0, w});
      end
    end
    ack_in = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    ack_in   = 1'b0;

    // Reset: three cycles held.
    repeat (3) tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_req", {31'd0, req_out}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
`ifdef HS_TIMEOUT_EN
    check("rst_err", {31'd0, err}, 32'd0);
`endif
    rst = 1'b0;
    repeat (2) tick();

    // Single transfer 0xA5; remote raises ack for edge 4.
    in_data  = 8'hA5;
    in_valid = 1'b1;
    tick();                                  // edge 0
    in_valid = 1'b0;
    exp_q.push_back(8'hA5);
    check("st_req_e0", {31'd0, req_out}, 32'd1);
    check("st_data_e0", {24'd0, data_out}, 32'hA5);
    check("st_busy_e0", {31'd0, busy}, 32'd1);
    check("st_ready_e0", {31'd0, in_ready}, 32'd0);
    tick();                                  // edge 1
    // Backpressure: a new word offered while in REQ must be ignored.
    in_data  = 8'h3C;
    in_valid = 1'b1;
    tick();                                  // edge 2
    check("bp_data_e2", {24'd0, data_out}, 32'hA5);
    check("bp_ready_e2", {31'd0, in_ready}, 32'd0);
    tick();                                  // edge 3
    ack_in = 1'b1;
    repeat (3) tick();                       // edges 4..6
    check("st_req_e6", {31'd0, req_out}, 32'd1);
    tick();                                  // edge 7
    check("st_req_e7", {31'd0, req_out}, 32'd0);
    check("st_data_e7", {24'd0, data_out}, 32'hA5);
    repeat (2) tick();                       // edges 8..9
    ack_in = 1'b0;
    repeat (3) tick();                       // edges 10..12
    check("st_done_e12", {31'd0, done}, 32'd0);
    check("st_ready_e12", {31'd0, in_ready}, 32'd0);
    check("bp_data_e12", {24'd0, data_out}, 32'hA5);
    tick();                                  // edge 13
    check("st_done_e13", {31'd0, done}, 32'd1);
    check("st_ready_e13", {31'd0, in_ready}, 32'd1);
    if (exp_q.size() != 0) check("sb_word_a5", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
    else                   check("sb_nonempty", 32'd0, 32'd1);
    tick();                                  // edge 14: 0x3C accepted now
    in_valid = 1'b0;
    exp_q.push_back(8'h3C);
    check("bp_data_e14", {24'd0, data_out}, 32'h3C);
    check("bp_req_e14", {31'd0, req_out}, 32'd1);
    check("st_done_e14", {31'd0, done}, 32'd0);
    complete(lat);
    check("bp_latency", lat, 2 * SYNC + 2);

    // Back-to-back with an immediate-ack remote.
    last_done_cyc = cyc;
    for (int k = 0; k < 3; k++) begin
      logic [WIDTH-1:0] words [3];
      words[0] = 8'h01;
      words[1] = 8'h80;
      words[2] = 8'hFF;
      accept_word(words[k], 1'b1);
      complete(lat);
      check("b2b_latency", lat, 2 * SYNC + 2);
      check("b2b_period_ge8", {31'd0, (cyc - last_done_cyc) >= 8}, 32'd1);
      last_done_cyc = cyc;
      tick();
      check("b2b_done_pulse", {31'd0, done}, 32'd0);
    end

    // Reset two cycles after accept: back to IDLE, then 0x55 transfers.
    accept_word(8'h77, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check("mid_rst_req", {31'd0, req_out}, 32'd0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_data", {24'd0, data_out}, 32'd0);
    rst = 1'b0;
    tick();
    accept_word(8'h55, 1'b1);
    complete(lat);
    check("post_rst_latency", lat, 2 * SYNC + 2);

`ifdef HS_TIMEOUT_EN
    // Timeout: ack never arrives; REQ aborts after TMO cycles.
    tick();
    ack_in = 1'b0;
    accept_word(8'h99, 1'b0);
    repeat (TMO - 1) tick();
    check("tmo_req_before", {31'd0, req_out}, 32'd1);
    check("tmo_err_before", {31'd0, err}, 32'd0);
    tick();
    check("tmo_req_drop", {31'd0, req_out}, 32'd0);
    check("tmo_err_set", {31'd0, err}, 32'd1);
    tick();
    check("tmo_idle", {31'd0, in_ready}, 32'd1);
    check("tmo_no_done", {31'd0, done}, 32'd0);
    tick();
    check("tmo_err_sticky", {31'd0, err}, 32'd1);
    check("tmo_no_done2", {31'd0, done}, 32'd0);
`endif

    check("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdc_handshake_tx.md
# cdc_handshake_tx

Source-side initiator of a four-phase req/ack crossing into the multiplier clock domain. Accepts one WIDTH-bit operand word per transaction on a valid/ready port, holds it stable on `data_out` and drives a level `req_out` that the remote domain synchronizes. The remote domain's asynchronous `ack_in` is synchronized locally. The block completes the return-to-zero phase before accepting the next word.

## Interface
- `WIDTH`, 8, operand word width
- `SYNC_STAGES`, 3, flop stages on `ack_in`, minimum 2
- `TIMEOUT_CYCLES`, 255, wait limit per phase; used only with `HS_TIMEOUT_EN`
- `clk` input 1: single clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `in_valid` input 1: upstream word valid
- `in_data` input WIDTH: upstream word
- `in_ready` output 1: block can accept; high exactly when state is IDLE
- `req_out` output 1: level request toward remote domain; registered, glitch-free
- `data_out` output WIDTH: registered word; stable from accept until return to IDLE
- `ack_in` input 1: asynchronous acknowledge from remote domain
- `busy` output 1: high whenever state is not IDLE
- `done` output 1: one-cycle pulse on normal completion
- `err` output 1: sticky timeout flag; present only with `HS_TIMEOUT_EN`

## Operation
- States:
  - IDLE: `req_out`=0
  - REQ: `req_out`=1, waiting for `ack_s`=1
  - REL: `req_out`=0, waiting for `ack_s`=0
- `ack_s` is the output of the last synchronizer stage. The FSM uses only `ack_s`, never `ack_in`.
- IDLE → REQ on `in_valid && in_ready`. The same edge loads `in_data` into `data_out` and sets `req_out`=1.
- In IDLE with `in_valid`=0, the block stays in IDLE and `data_out` holds its last value.
- REQ → REL on the first edge where `ack_s`=1. `req_out` falls on that edge.
- REL → IDLE on the first edge where `ack_s`=0. `done` pulses high for the following cycle.
- `in_valid` outside IDLE is ignored. `in_data` changes outside IDLE have no effect on `data_out`.
- `ack_s` already high while in IDLE (spurious ack or remote lag): no effect. The next transaction's REQ waits for a fresh rising edge only in the sense of full four-phase order; the REQ exit condition is simply `ack_s`=1.
- `rst` asserted mid-transaction: on the next edge, state goes to IDLE, `req_out`=0 and synchronizer flops clear. The remote side is responsible for recovering from the dropped request.

## Timing
- Reset values (all synchronous): state IDLE, `in_ready`=1, `req_out`=0, `data_out`=0, `busy`=0, `done`=0, `err`=0, all sync stages 0.
- Accept at edge a: `req_out`=1, `busy`=1 and `in_ready`=0 visible after edge a.
- Edge k is the first edge sampling `ack_in`=1. `ack_s`=1 after edge k+SYNC_STAGES−1, and `req_out` falls after edge k+SYNC_STAGES.
- The ack falling edge has the same SYNC_STAGES latency to REL → IDLE.
- `in_ready` returns high on the same edge that produces `done`=1.
- Minimum back-to-back period: 2·SYNC_STAGES + 2 cycles plus remote latency.

## Configuration
- Macro: `HS_TIMEOUT_EN`.
- Defined:
  - A cycle counter clears on every state change and counts while in REQ or REL.
  - Reaching TIMEOUT_CYCLES in REQ forces REL: `req_out` drops and `err` is set.
  - Reaching TIMEOUT_CYCLES in REL forces IDLE: `err` is set and `done` does not pulse.
  - `err` stays high until `rst`.
- Undefined: no counter and no `err` port. The FSM waits indefinitely in REQ and REL.

## Structure
- Shared package `cdc_pkg` holds:
  - state enum `hs_state_t` (IDLE, REQ, REL)
  - default constants `CDC_SYNC_STAGES`=3 and `CDC_TIMEOUT_CYCLES`=255
- One sub-module, `ack_sync`: a SYNC_STAGES-deep flop chain with synchronous reset, input `ack_in`, output `ack_s`.

## Test plan
- Reset: hold `rst` 3 cycles → `in_ready`=1, `req_out`=0, `data_out`=0x00, `busy`=0, `done`=0.
- Single transfer: `in_data`=0xA5 with `in_valid` at edge 0; model raises `ack_in` at edge 4 and drops it 2 cycles after `req_out` falls.
  - `data_out`=0xA5 and `req_out`=1 after edge 0.
  - `req_out`=0 after edge 7.
  - `done` pulses once; 0xA5 is held throughout.
- Backpressure: in REQ, drive `in_valid` with 0x3C → ignored. `data_out` stays 0xA5 and 0x3C is accepted only after `in_ready` returns.
- Back-to-back: 0x01, 0x80, 0xFF with an immediate-ack model → three `done` pulses, each period ≥ 8 cycles, words delivered in order.
- Reset mid-REQ: assert `rst` 2 cycles after accept → `req_out`=0 and IDLE after that edge; the next word 0x55 transfers normally.
- `HS_TIMEOUT_EN`, TIMEOUT_CYCLES=16, `ack_in` tied 0 → `req_out` drops 16 cycles after accept, `err`=1 and stays high, and the block returns to IDLE with no `done` pulse.
